// File: rtl/stage_sequencer_if.sv
// Handshake bundle between the instruction-phase sequencer and the core:
// run/step/flush control, per-stage acks in, stage enables and status out.
interface stage_sequencer_if #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32
);
    logic                  run;
    logic                  step;
    logic                  flush;
    logic [NUM_STAGES-1:0] ack_mask;
    logic [NUM_STAGES-1:0] stage_ack;
    logic [NUM_STAGES-1:0] stage_en;
    logic [NUM_STAGES-1:0] stage_start;
    logic                  inst_done;
    logic [CNT_W-1:0]      retired;
    logic                  busy;

    modport master (
        output run, step, flush, ack_mask, stage_ack,
        input  stage_en, stage_start, inst_done, retired, busy
    );

    modport slave (
        input  run, step, flush, ack_mask, stage_ack,
        output stage_en, stage_start, inst_done, retired, busy
    );
endinterface

// File: rtl/stage_sequencer.sv
// One-hot instruction-phase sequencer: steps NUM_STAGES phases on a single
// clock, with per-stage ack handshakes, run/step, flush and a retire counter.
//
// state  | meaning
// IDLE   | no instruction in flight, waiting for run or step
// ACTIVE | stage idx enabled, waiting for it to complete
module stage_sequencer #(
    parameter int NUM_STAGES = 4,
    parameter int CNT_W      = 32
) (
    input  logic          clk,
    input  logic          reset,
    stage_sequencer_if.slave bus
);
    localparam int IDX_W = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_STAGES - 1);

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             stage_done;

    function automatic logic [NUM_STAGES-1:0] onehot(input logic [IDX_W-1:0] i);
        return NUM_STAGES'(1) << i;
    endfunction

    // Unmasked stages complete in one cycle; acks are only looked at for the
    // stage currently enabled, so stray acks are never remembered.
    assign stage_done = ~bus.ack_mask[idx] | bus.stage_ack[idx];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            idx             <= '0;
            bus.stage_en    <= '0;
            bus.stage_start <= '0;
            bus.inst_done   <= 1'b0;
            bus.retired     <= '0;
            bus.busy        <= 1'b0;
        end else begin
            bus.stage_start <= '0;
            bus.inst_done   <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.run || bus.step) begin
                        state           <= ACTIVE;
                        idx             <= '0;
                        bus.stage_en    <= onehot(IDX_W'(0));
                        bus.stage_start <= onehot(IDX_W'(0));
                        bus.busy        <= 1'b1;
                    end
                end
                ACTIVE: begin
                    // Flush shares the end-of-instruction path but never retires.
                    if (bus.flush || (stage_done && idx == LAST_IDX)) begin
                        if (!bus.flush) begin
                            bus.inst_done <= 1'b1;
                            bus.retired   <= bus.retired + CNT_W'(1);
                        end
                        if (bus.run) begin
                            idx             <= '0;
                            bus.stage_en    <= onehot(IDX_W'(0));
                            bus.stage_start <= onehot(IDX_W'(0));
                        end else begin
                            state        <= IDLE;
                            idx          <= '0;
                            bus.stage_en <= '0;
                            bus.busy     <= 1'b0;
                        end
                    end else if (stage_done) begin
                        idx             <= idx + IDX_W'(1);
                        bus.stage_en    <= onehot(idx + IDX_W'(1));
                        bus.stage_start <= onehot(idx + IDX_W'(1));
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
